// File: rtl/tx_frame_sched.sv
// tx_frame_sched: round-robin burst arbiter between two capture FIFOs and the tx framer.
// Whole BURST-word frames stream through a 2-entry skid buffer, followed by an IFG idle gap.
module tx_frame_sched #(
  parameter int DW    = 40,
  parameter int LW    = 10,
  parameter int BURST = 32,
  parameter int IFG   = 12
) (
  input  logic          clk125,
  input  logic          reset,
  input  logic          enable,
  input  logic [LW-1:0] req0_level,
  output logic          req0_rden,
  input  logic [DW-1:0] req0_data,
  input  logic [LW-1:0] req1_level,
  output logic          req1_rden,
  input  logic [DW-1:0] req1_data,
  input  logic          tx_ready,
  output logic          tx_valid,
  output logic [DW-1:0] tx_data,
  output logic          tx_sof,
  output logic          tx_eof,
  output logic          tx_chan,
  output logic          busy,
  output logic [15:0]   frames0,
  output logic [15:0]   frames1
);
  localparam int            GW       = (IFG > 1) ? $clog2(IFG) : 1;
  localparam logic [LW-1:0] BURST_L  = LW'(BURST);
  localparam logic [LW-1:0] ONE_L    = LW'(1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(IFG - 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;
  state_t state, state_nx;

  logic [1:0][DW-1:0] fifo_q;
  logic [1:0][DW-1:0] skid;
  logic [1:0][15:0]   frames;
  logic [1:0]         elig;
  logic [1:0]         occ;
  logic               chan, last, inflight;
  logic               grant, grant_ch, rd_ok, pop, last_pop;
  logic [LW-1:0]      rd_cnt, snd_cnt;
  logic [GW-1:0]      gap_cnt;

  assign fifo_q  = {req1_data, req0_data};
  assign elig[0] = enable && (req0_level >= BURST_L);
  assign elig[1] = enable && (req1_level >= BURST_L);
  assign grant    = (elig != 2'b00);
  assign grant_ch = (elig == 2'b11) ? ~last : elig[1];

  assign tx_valid = (occ != 2'd0);
  assign pop      = tx_valid && tx_ready;
  assign last_pop = pop && (snd_cnt == ONE_L);

  // Words held plus the one in flight, less this cycle's pop, must leave room for one more.
  assign rd_ok = (state == S_BURST) && (rd_cnt != '0) &&
                 (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  assign req0_rden = rd_ok && !chan;
  assign req1_rden = rd_ok && chan;

  assign tx_data = skid[0];
  assign tx_sof  = tx_valid && (snd_cnt == BURST_L);
  assign tx_eof  = tx_valid && (snd_cnt == ONE_L);
  assign tx_chan = chan;
  assign busy    = (state != S_IDLE);
  assign frames0 = frames[0];
  assign frames1 = frames[1];

  always_ff @(posedge clk125 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (grant) state_nx = S_BURST;
      S_BURST: if (last_pop) state_nx = S_GAP;
      S_GAP:   if (gap_cnt == '0) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk125 or posedge reset) begin
    if (reset) begin
      chan     <= 1'b0;
      last     <= 1'b1;
      inflight <= 1'b0;
      rd_cnt   <= '0;
      snd_cnt  <= '0;
      gap_cnt  <= '0;
      occ      <= '0;
      skid     <= '0;
      frames   <= '0;
    end else begin
      inflight <= rd_ok;
      if (state == S_IDLE && grant) begin
        chan    <= grant_ch;
        rd_cnt  <= BURST_L;
        snd_cnt <= BURST_L;
      end
      if (rd_ok) rd_cnt  <= rd_cnt - ONE_L;
      if (pop)   snd_cnt <= snd_cnt - ONE_L;
      if (last_pop) begin
        frames[chan] <= frames[chan] + 16'd1;
        last         <= chan;
        gap_cnt      <= GAP_LOAD;
      end else if (state == S_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
      // FIFO Q lands one cycle after rden; skid[0] is always the head.
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) skid[0] <= fifo_q[chan];
          else             skid[1] <= fifo_q[chan];
          occ <= occ + 2'd1;
        end
        2'b01: begin
          skid[0] <= skid[1];
          occ     <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            skid[0] <= fifo_q[chan];
          end else begin
            skid[0] <= skid[1];
            skid[1] <= fifo_q[chan];
          end
        end
        default: begin end
      endcase
    end
  end
endmodule
